control_unit: RTL and testbench
===============================

// Module: control_unit
// PURPOSE
//  Hardwired Moore-style sequencer that drives every datapath control input (bus drivers, register loads,
//  Gra/Grb/Grc/Rin/Rout, Read/Write/IncPC, CONin) from the present T-state and the IR opcode.
//  Sits beside datapath, replacing the bench-driven control. One T-state per Clock, fetch T0-T2, execute T3-T7.
// PARAMETERS
//  OPC_W  5  opcode width, taken from IR[31:27]
// PORTS
//  Clock      in   1   system clock, all state changes on posedge
//  Reset      in   1   synchronous, active-high
//  IR         in   32  instruction register from datapath (opcode = IR[31:27])
//  CON_FF     in   1   branch-condition flag from datapath
//  drv        out  9   bus drivers {Cout,BAout,InPortout,MDRout,LOout,HIout,Zlowout,Zhighout,PCout} [8:0]
//  ld         out  10  loads {CONin,OutPortin,IRin,LOin,HIin,Yin,MDRin,MARin,Zin,PCin} [9:0]
//  rsel       out  5   {Rout,Rin,Grc,Grb,Gra} [4:0]
//  mem        out  3   {IncPC,Write,Read} [2:0]
//  alu_op     out  5   ALU operation, meaningful only while ld.Zin=1
//  Run        out  1   1 while executing, 0 in HALT (and STOPPED)
// BEHAVIOUR
//  - Reset sampled high: state<=RST; every output 0, Run=0. RST->T0 on next edge. Reset mid-instruction aborts it, no further writes.
//  - Outputs combinational from state+IR; at most one drv bit high in any state. Read is single-cycle memory.
//  - Fetch: T0 PCout,MARin,IncPC,Zin | T1 Zlowout,PCin,Read,MDRin | T2 MDRout,IRin.
//  - ALU R (add,sub,shr,shra,shl,ror,rol,and,or): T3 Grb,Rout,Yin | T4 Grc,Rout,Zin | T5 Zlowout,Gra,Rin.
//  - ALU I (addi,andi,ori): T3 Grb,Rout,Yin | T4 Cout,Zin | T5 Zlowout,Gra,Rin.
//  - neg,not: T3 Grb,Rout,Zin | T4 Zlowout,Gra,Rin.   mul,div: T3 Gra,Rout,Yin | T4 Grb,Rout,Zin | T5 Zlowout,LOin | T6 Zhighout,HIin.
//  - ld: T3 Grb,BAout,Yin | T4 Cout,Zin | T5 Zlowout,MARin | T6 Read,MDRin | T7 MDRout,Gra,Rin.   ldi: T3,T4 as ld | T5 Zlowout,Gra,Rin.
//  - st: T3-T5 as ld | T6 Gra,Rout,MDRin | T7 Write.
//  - brx: T3 Gra,Rout,CONin | T4 PCout,Yin | T5 Cout,Zin | T6 Zlowout,PCin only if CON_FF=1 (else T6 all 0).
//  - jr: T3 Gra,Rout,PCin.  jal: T3 PCout,Grb,Rin | T4 Gra,Rout,PCin.
//  - in: T3 InPortout,Gra,Rin.  out: T3 Gra,Rout,OutPortin.  mfhi/mflo: T3 HIout/LOout,Gra,Rin.
//  - Last execute state of each class -> T0. nop and undefined opcodes: T3 all 0 -> T0.
//  - halt: T3 -> HALT; HALT holds, all outputs 0, Run=0, exits only on Reset.
//  - alu_op = ADD (00011) in T0, and in ld/ldi/st T4 and brx T5; otherwise IR[31:27].
//  - Opcodes: ld 00000 ldi 00001 st 00010 add 00011 sub 00100 shr 00101 shra 00110 shl 00111 ror 01000 rol 01001
//    and 01010 or 01011 addi 01100 andi 01101 ori 01110 mul 01111 div 10000 neg 10001 not 10010 brx 10011
//    jr 10100 jal 10101 in 10110 out 10111 mfhi 11000 mflo 11001 nop 11010 halt 11011.
// CONFIGURATION
//  - CU_STOP_EN defined: extra input Stop (1 bit). On any edge where next state would be T0 and Stop=1,
//    go to STOPPED (outputs 0, Run=0) instead. STOPPED->T0 on first edge with Stop=0; Reset overrides.
//  - CU_STOP_EN undefined: no Stop port, no STOPPED state; Run=0 only in RST and HALT.
// STRUCTURE
//  - cu_pkg: opcode constants, state enum {RST,T0..T7,HALT,STOPPED}, instruction-class enum,
//    bit-index constants for drv/ld/rsel/mem.
//  - Sub-module cu_decode: combinational opcode -> class, last-state and alu_op-override decode.
//  - Top: state register + next-state logic + output decode.
// TESTING
//  - Reset 2 cycles, mem[0]=add R3,R1,R2 -> T0 drv.PCout,ld.MARin,mem.IncPC; T1 Read,PCin; T2 IRin; T5 Rin+Gra; T0 at cycle 6.
//  - ld R1,0x55(R2) -> T4 Cout+Zin alu_op=00011; T6 Read+MDRin; T7 MDRout+Gra+Rin; then T0.
//  - brzr, CON_FF=0 -> T6 PCin=0; repeat with CON_FF=1 -> T6 Zlowout+PCin=1.
//  - mul R2,R4 -> T5 Zlowout+LOin, T6 Zhighout+HIin, alu_op=01111 at T4.
//  - halt -> Run=0, all outputs 0 for 20 cycles; Reset during T4 of add -> RST next cycle, Rin never asserted.
//  - CU_STOP_EN: Stop=1 during out instruction -> STOPPED after T3, Run=0; Stop=0 -> T0 next edge.

Source files
------------

// File: rtl/cu_pkg.sv
// cu_pkg: shared definitions for the hardwired control unit.
//   - opcode constants (IR[31:27])
//   - sequencer state enum and instruction-class enum
//   - bit positions inside the drv / ld / rsel / mem control buses
package cu_pkg;

  localparam int OPC_W = 5;

  localparam logic [OPC_W-1:0] OP_LD   = 5'b00000;
  localparam logic [OPC_W-1:0] OP_LDI  = 5'b00001;
  localparam logic [OPC_W-1:0] OP_ST   = 5'b00010;
  localparam logic [OPC_W-1:0] OP_ADD  = 5'b00011;
  localparam logic [OPC_W-1:0] OP_SUB  = 5'b00100;
  localparam logic [OPC_W-1:0] OP_SHR  = 5'b00101;
  localparam logic [OPC_W-1:0] OP_SHRA = 5'b00110;
  localparam logic [OPC_W-1:0] OP_SHL  = 5'b00111;
  localparam logic [OPC_W-1:0] OP_ROR  = 5'b01000;
  localparam logic [OPC_W-1:0] OP_ROL  = 5'b01001;
  localparam logic [OPC_W-1:0] OP_AND  = 5'b01010;
  localparam logic [OPC_W-1:0] OP_OR   = 5'b01011;
  localparam logic [OPC_W-1:0] OP_ADDI = 5'b01100;
  localparam logic [OPC_W-1:0] OP_ANDI = 5'b01101;
  localparam logic [OPC_W-1:0] OP_ORI  = 5'b01110;
  localparam logic [OPC_W-1:0] OP_MUL  = 5'b01111;
  localparam logic [OPC_W-1:0] OP_DIV  = 5'b10000;
  localparam logic [OPC_W-1:0] OP_NEG  = 5'b10001;
  localparam logic [OPC_W-1:0] OP_NOT  = 5'b10010;
  localparam logic [OPC_W-1:0] OP_BRX  = 5'b10011;
  localparam logic [OPC_W-1:0] OP_JR   = 5'b10100;
  localparam logic [OPC_W-1:0] OP_JAL  = 5'b10101;
  localparam logic [OPC_W-1:0] OP_IN   = 5'b10110;
  localparam logic [OPC_W-1:0] OP_OUT  = 5'b10111;
  localparam logic [OPC_W-1:0] OP_MFHI = 5'b11000;
  localparam logic [OPC_W-1:0] OP_MFLO = 5'b11001;
  localparam logic [OPC_W-1:0] OP_NOP  = 5'b11010;
  localparam logic [OPC_W-1:0] OP_HALT = 5'b11011;

  typedef enum logic [3:0] {
    S_RST, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT, S_STOPPED
  } state_t;

  typedef enum logic [3:0] {
    C_NOP, C_ALU_R, C_ALU_I, C_UNARY, C_MULDIV, C_LD, C_LDI, C_ST,
    C_BRX, C_JR, C_JAL, C_IN, C_OUT, C_MFHI, C_MFLO, C_HALT
  } iclass_t;

  // drv {Cout,BAout,InPortout,MDRout,LOout,HIout,Zlowout,Zhighout,PCout}
  localparam int DRV_PCOUT  = 0;
  localparam int DRV_ZHIGH  = 1;
  localparam int DRV_ZLOW   = 2;
  localparam int DRV_HI     = 3;
  localparam int DRV_LO     = 4;
  localparam int DRV_MDR    = 5;
  localparam int DRV_INPORT = 6;
  localparam int DRV_BA     = 7;
  localparam int DRV_C      = 8;

  // ld {CONin,OutPortin,IRin,LOin,HIin,Yin,MDRin,MARin,Zin,PCin}
  localparam int LD_PCIN      = 0;
  localparam int LD_ZIN       = 1;
  localparam int LD_MARIN     = 2;
  localparam int LD_MDRIN     = 3;
  localparam int LD_YIN       = 4;
  localparam int LD_HIIN      = 5;
  localparam int LD_LOIN      = 6;
  localparam int LD_IRIN      = 7;
  localparam int LD_OUTPORTIN = 8;
  localparam int LD_CONIN     = 9;

  // rsel {Rout,Rin,Grc,Grb,Gra}
  localparam int RS_GRA  = 0;
  localparam int RS_GRB  = 1;
  localparam int RS_GRC  = 2;
  localparam int RS_RIN  = 3;
  localparam int RS_ROUT = 4;

  // mem {IncPC,Write,Read}
  localparam int MEM_READ  = 0;
  localparam int MEM_WRITE = 1;
  localparam int MEM_INCPC = 2;

endpackage

// File: rtl/cu_decode.sv
// cu_decode: combinational opcode decode for the control unit.
//   opc        in  opcode field IR[31:27]
//   iclass     out instruction class
//   last_state out final execute T-state of this class
//   add_state  out execute T-state where the ALU is forced to ADD for
//                  address/offset arithmetic (S_T0 when the class has none)
module cu_decode
  import cu_pkg::*;
(
  input  logic [OPC_W-1:0] opc,
  output iclass_t          iclass,
  output state_t           last_state,
  output state_t           add_state
);

  always_comb begin
    iclass = C_NOP;
    case (opc)
      OP_ADD, OP_SUB, OP_SHR, OP_SHRA, OP_SHL,
      OP_ROR, OP_ROL, OP_AND, OP_OR:        iclass = C_ALU_R;
      OP_ADDI, OP_ANDI, OP_ORI:             iclass = C_ALU_I;
      OP_NEG, OP_NOT:                       iclass = C_UNARY;
      OP_MUL, OP_DIV:                       iclass = C_MULDIV;
      OP_LD:                                iclass = C_LD;
      OP_LDI:                               iclass = C_LDI;
      OP_ST:                                iclass = C_ST;
      OP_BRX:                               iclass = C_BRX;
      OP_JR:                                iclass = C_JR;
      OP_JAL:                               iclass = C_JAL;
      OP_IN:                                iclass = C_IN;
      OP_OUT:                               iclass = C_OUT;
      OP_MFHI:                              iclass = C_MFHI;
      OP_MFLO:                              iclass = C_MFLO;
      OP_HALT:                              iclass = C_HALT;
      default:                              iclass = C_NOP;
    endcase
  end

  always_comb begin
    last_state = S_T3;
    add_state  = S_T0;
    case (iclass)
      C_ALU_R, C_ALU_I: last_state = S_T5;
      C_UNARY, C_JAL:   last_state = S_T4;
      C_MULDIV:         last_state = S_T6;
      C_LD, C_ST: begin
        last_state = S_T7;
        add_state  = S_T4;
      end
      C_LDI: begin
        last_state = S_T5;
        add_state  = S_T4;
      end
      C_BRX: begin
        last_state = S_T6;
        add_state  = S_T5;
      end
      default:          last_state = S_T3;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// control_unit: hardwired sequencer driving all datapath control inputs
// from the present T-state and the IR opcode. Fetch is T0-T2, execute T3-T7.
//
// Ports:
//   Clock   in   system clock (posedge)
//   Reset   in   synchronous active-high reset
//   IR      in   instruction register, opcode in IR[31:27]
//   CON_FF  in   branch-condition flag
//   Stop    in   (CU_STOP_EN only) park in STOPPED instead of fetching
//   drv     out  bus drivers, one-hot or zero
//   ld      out  register loads
//   rsel    out  register-file select/enable
//   mem     out  {IncPC,Write,Read}
//   alu_op  out  ALU operation, meaningful while ld[LD_ZIN]=1
//   Run     out  1 while sequencing instructions
//
// Build option: define CU_STOP_EN to add the Stop input and STOPPED state.
//
// state     | meaning
// ----------+--------------------------------------------------
// S_RST     | reset held, all outputs 0
// S_T0-T2   | instruction fetch
// S_T3-T7   | execute; length depends on instruction class
// S_HALT    | halted, outputs 0, left only by Reset
// S_STOPPED | parked before fetch while Stop=1 (CU_STOP_EN)
module control_unit
  import cu_pkg::*;
(
  input  logic        Clock,
  input  logic        Reset,
  input  logic [31:0] IR,
  input  logic        CON_FF,
`ifdef CU_STOP_EN
  input  logic        Stop,
`endif
  output logic [8:0]  drv,
  output logic [9:0]  ld,
  output logic [4:0]  rsel,
  output logic [2:0]  mem,
  output logic [4:0]  alu_op,
  output logic        Run
);

  state_t           state, state_seq, state_nxt, end_state;
  state_t           last_state, add_state;
  iclass_t          iclass;
  logic [OPC_W-1:0] opc;
  logic             unused_ir;

  assign opc       = IR[31:27];
  assign unused_ir = ^IR[26:0];

  cu_decode u_decode (
    .opc        (opc),
    .iclass     (iclass),
    .last_state (last_state),
    .add_state  (add_state)
  );

  always_ff @(posedge Clock) begin
    if (Reset) state <= S_RST;
    else       state <= state_nxt;
  end

  assign end_state = (iclass == C_HALT) ? S_HALT : S_T0;

  always_comb begin
    state_seq = S_RST;
    case (state)
      S_RST:     state_seq = S_T0;
      S_T0:      state_seq = S_T1;
      S_T1:      state_seq = S_T2;
      S_T2:      state_seq = S_T3;
      S_T3:      state_seq = (state == last_state) ? end_state : S_T4;
      S_T4:      state_seq = (state == last_state) ? end_state : S_T5;
      S_T5:      state_seq = (state == last_state) ? end_state : S_T6;
      S_T6:      state_seq = (state == last_state) ? end_state : S_T7;
      S_T7:      state_seq = end_state;
      S_HALT:    state_seq = S_HALT;
`ifdef CU_STOP_EN
      S_STOPPED: state_seq = S_T0;
`endif
      default:   state_seq = S_RST;
    endcase
  end

  // Every route back into fetch passes through this check, so Stop is
  // honoured both after reset and between instructions.
`ifdef CU_STOP_EN
  assign state_nxt = (state_seq == S_T0 && Stop) ? S_STOPPED : state_seq;
`else
  assign state_nxt = state_seq;
`endif

  always_comb begin
    drv    = '0;
    ld     = '0;
    rsel   = '0;
    mem    = '0;
    alu_op = '0;
    Run    = 1'b0;
    if (state inside {S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7}) begin
      Run    = 1'b1;
      alu_op = (state == S_T0 || state == add_state) ? OP_ADD : opc;
    end
    case (state)
      S_T0: begin
        drv[DRV_PCOUT] = 1'b1; ld[LD_MARIN] = 1'b1; ld[LD_ZIN] = 1'b1; mem[MEM_INCPC] = 1'b1;
      end
      S_T1: begin
        drv[DRV_ZLOW] = 1'b1; ld[LD_PCIN] = 1'b1; ld[LD_MDRIN] = 1'b1; mem[MEM_READ] = 1'b1;
      end
      S_T2: begin
        drv[DRV_MDR] = 1'b1; ld[LD_IRIN] = 1'b1;
      end
      S_T3: begin
        case (iclass)
          C_ALU_R, C_ALU_I: begin rsel[RS_GRB] = 1'b1; rsel[RS_ROUT] = 1'b1; ld[LD_YIN] = 1'b1; end
          C_UNARY:          begin rsel[RS_GRB] = 1'b1; rsel[RS_ROUT] = 1'b1; ld[LD_ZIN] = 1'b1; end
          C_MULDIV:         begin rsel[RS_GRA] = 1'b1; rsel[RS_ROUT] = 1'b1; ld[LD_YIN] = 1'b1; end
          C_LD, C_LDI, C_ST: begin rsel[RS_GRB] = 1'b1; drv[DRV_BA] = 1'b1; ld[LD_YIN] = 1'b1; end
          C_BRX:            begin rsel[RS_GRA] = 1'b1; rsel[RS_ROUT] = 1'b1; ld[LD_CONIN] = 1'b1; end
          C_JR:             begin rsel[RS_GRA] = 1'b1; rsel[RS_ROUT] = 1'b1; ld[LD_PCIN] = 1'b1; end
          C_JAL:            begin drv[DRV_PCOUT] = 1'b1; rsel[RS_GRB] = 1'b1; rsel[RS_RIN] = 1'b1; end
          C_IN:             begin drv[DRV_INPORT] = 1'b1; rsel[RS_GRA] = 1'b1; rsel[RS_RIN] = 1'b1; end
          C_OUT:            begin rsel[RS_GRA] = 1'b1; rsel[RS_ROUT] = 1'b1; ld[LD_OUTPORTIN] = 1'b1; end
          C_MFHI:           begin drv[DRV_HI] = 1'b1; rsel[RS_GRA] = 1'b1; rsel[RS_RIN] = 1'b1; end
          C_MFLO:           begin drv[DRV_LO] = 1'b1; rsel[RS_GRA] = 1'b1; rsel[RS_RIN] = 1'b1; end
          default: ;
        endcase
      end
      S_T4: begin
        case (iclass)
          C_ALU_R:          begin rsel[RS_GRC] = 1'b1; rsel[RS_ROUT] = 1'b1; ld[LD_ZIN] = 1'b1; end
          C_ALU_I, C_LD, C_LDI, C_ST: begin drv[DRV_C] = 1'b1; ld[LD_ZIN] = 1'b1; end
          C_UNARY:          begin drv[DRV_ZLOW] = 1'b1; rsel[RS_GRA] = 1'b1; rsel[RS_RIN] = 1'b1; end
          C_MULDIV:         begin rsel[RS_GRB] = 1'b1; rsel[RS_ROUT] = 1'b1; ld[LD_ZIN] = 1'b1; end
          C_BRX:            begin drv[DRV_PCOUT] = 1'b1; ld[LD_YIN] = 1'b1; end
          C_JAL:            begin rsel[RS_GRA] = 1'b1; rsel[RS_ROUT] = 1'b1; ld[LD_PCIN] = 1'b1; end
          default: ;
        endcase
      end
      S_T5: begin
        case (iclass)
          C_ALU_R, C_ALU_I, C_LDI: begin drv[DRV_ZLOW] = 1'b1; rsel[RS_GRA] = 1'b1; rsel[RS_RIN] = 1'b1; end
          C_MULDIV:         begin drv[DRV_ZLOW] = 1'b1; ld[LD_LOIN] = 1'b1; end
          C_LD, C_ST:       begin drv[DRV_ZLOW] = 1'b1; ld[LD_MARIN] = 1'b1; end
          C_BRX:            begin drv[DRV_C] = 1'b1; ld[LD_ZIN] = 1'b1; end
          default: ;
        endcase
      end
      S_T6: begin
        case (iclass)
          C_MULDIV:         begin drv[DRV_ZHIGH] = 1'b1; ld[LD_HIIN] = 1'b1; end
          C_LD:             begin mem[MEM_READ] = 1'b1; ld[LD_MDRIN] = 1'b1; end
          C_ST:             begin rsel[RS_GRA] = 1'b1; rsel[RS_ROUT] = 1'b1; ld[LD_MDRIN] = 1'b1; end
          // Branch target is only committed when the condition held.
          C_BRX: if (CON_FF) begin drv[DRV_ZLOW] = 1'b1; ld[LD_PCIN] = 1'b1; end
          default: ;
        endcase
      end
      S_T7: begin
        case (iclass)
          C_LD:             begin drv[DRV_MDR] = 1'b1; rsel[RS_GRA] = 1'b1; rsel[RS_RIN] = 1'b1; end
          C_ST:             mem[MEM_WRITE] = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
module tb_control_unit;

  typedef logic [26:0] cw_t;           // {drv, ld, rsel, mem}
  typedef cw_t cw_q_t[$];

  localparam logic [8:0] D_C = 9'h100, D_BA = 9'h080, D_IN = 9'h040, D_MDR = 9'h020,
                         D_LO = 9'h010, D_HI = 9'h008, D_ZL = 9'h004, D_ZH = 9'h002, D_PC = 9'h001;
  localparam logic [9:0] L_CON = 10'h200, L_OUTP = 10'h100, L_IR = 10'h080, L_LO = 10'h040,
                         L_HI = 10'h020, L_Y = 10'h010, L_MDR = 10'h008, L_MAR = 10'h004,
                         L_Z = 10'h002, L_PC = 10'h001;
  localparam logic [4:0] R_OUT = 5'h10, R_IN = 5'h08, R_C = 5'h04, R_B = 5'h02, R_A = 5'h01;
  localparam logic [2:0] M_INC = 3'h4, M_W = 3'h2, M_R = 3'h1;

  logic        Clock;
  logic        Reset;
  logic [31:0] IR;
  logic        CON_FF;
  logic        Stop;
  logic [8:0]  drv;
  logic [9:0]  ld;
  logic [4:0]  rsel;
  logic [2:0]  mem;
  logic [4:0]  alu_op;
  logic        Run;

  int n_checks = 0;
  int n_fail   = 0;

  control_unit dut (
    .Clock  (Clock),
    .Reset  (Reset),
    .IR     (IR),
    .CON_FF (CON_FF),
`ifdef CU_STOP_EN
    .Stop   (Stop),
`endif
    .drv    (drv),
    .ld     (ld),
    .rsel   (rsel),
    .mem    (mem),
    .alu_op (alu_op),
    .Run    (Run)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic cw_t w(input logic [8:0] d, input logic [9:0] l,
                            input logic [4:0] r, input logic [2:0] m);
    return {d, l, r, m};
  endfunction

  // Execute-phase micro-steps (T3 onward) of each instruction, as listed
  // in the instruction table.
  function automatic cw_q_t exec_seq(input logic [4:0] op, input logic con);
    cw_q_t q;
    if (op >= 5'd3 && op <= 5'd11) begin
      q.push_back(w(0, L_Y, R_B | R_OUT, 0));
      q.push_back(w(0, L_Z, R_C | R_OUT, 0));
      q.push_back(w(D_ZL, 0, R_A | R_IN, 0));
    end else if (op >= 5'd12 && op <= 5'd14) begin
      q.push_back(w(0, L_Y, R_B | R_OUT, 0));
      q.push_back(w(D_C, L_Z, 0, 0));
      q.push_back(w(D_ZL, 0, R_A | R_IN, 0));
    end else if (op == 5'd15 || op == 5'd16) begin
      q.push_back(w(0, L_Y, R_A | R_OUT, 0));
      q.push_back(w(0, L_Z, R_B | R_OUT, 0));
      q.push_back(w(D_ZL, L_LO, 0, 0));
      q.push_back(w(D_ZH, L_HI, 0, 0));
    end else if (op == 5'd17 || op == 5'd18) begin
      q.push_back(w(0, L_Z, R_B | R_OUT, 0));
      q.push_back(w(D_ZL, 0, R_A | R_IN, 0));
    end else if (op <= 5'd2) begin
      q.push_back(w(D_BA, L_Y, R_B, 0));
      q.push_back(w(D_C, L_Z, 0, 0));
      if (op == 5'd1) begin
        q.push_back(w(D_ZL, 0, R_A | R_IN, 0));
      end else begin
        q.push_back(w(D_ZL, L_MAR, 0, 0));
        if (op == 5'd0) begin
          q.push_back(w(0, L_MDR, 0, M_R));
          q.push_back(w(D_MDR, 0, R_A | R_IN, 0));
        end else begin
          q.push_back(w(0, L_MDR, R_A | R_OUT, 0));
          q.push_back(w(0, 0, 0, M_W));
        end
      end
    end else if (op == 5'd19) begin
      q.push_back(w(0, L_CON, R_A | R_OUT, 0));
      q.push_back(w(D_PC, L_Y, 0, 0));
      q.push_back(w(D_C, L_Z, 0, 0));
      q.push_back(con ? w(D_ZL, L_PC, 0, 0) : w(0, 0, 0, 0));
    end else if (op == 5'd20) q.push_back(w(0, L_PC, R_A | R_OUT, 0));
    else if (op == 5'd21) begin
      q.push_back(w(D_PC, 0, R_B | R_IN, 0));
      q.push_back(w(0, L_PC, R_A | R_OUT, 0));
    end
    else if (op == 5'd22) q.push_back(w(D_IN, 0, R_A | R_IN, 0));
    else if (op == 5'd23) q.push_back(w(0, L_OUTP, R_A | R_OUT, 0));
    else if (op == 5'd24) q.push_back(w(D_HI, 0, R_A | R_IN, 0));
    else if (op == 5'd25) q.push_back(w(D_LO, 0, R_A | R_IN, 0));
    else q.push_back(w(0, 0, 0, 0));   // nop, halt, undefined
    return q;
  endfunction

  function automatic cw_t fetch_cw(input int k);
    if (k == 0) return w(D_PC, L_MAR | L_Z, 0, M_INC);
    if (k == 1) return w(D_ZL, L_PC | L_MDR, 0, M_R);
    return w(D_MDR, L_IR, 0, 0);
  endfunction

  function automatic logic [4:0] exp_alu(input logic [4:0] op, input int k);
    if (k == 0) return 5'd3;
    if (op <= 5'd2 && k == 4) return 5'd3;
    if (op == 5'd19 && k == 5) return 5'd3;
    return op;
  endfunction

  // Runs one whole instruction starting just after the edge into T0,
  // checking every T-state against the model.
  task automatic run_instr(input logic [4:0] op, input logic con, input string tag);
    cw_q_t       ex;
    int          n;
    logic [31:0] r;
    logic [32:0] expv, got;
    r      = $urandom();
    IR     = {op, r[26:0]};
    CON_FF = con;
    ex     = exec_seq(op, con);
    n      = 3 + ex.size();
    for (int k = 0; k < n; k++) begin
      @(negedge Clock);
      expv = {(k < 3) ? fetch_cw(k) : ex[k-3], exp_alu(op, k), 1'b1};
      got  = {drv, ld, rsel, mem, alu_op, Run};
      n_checks++;
      if (got !== expv) begin
        n_fail++;
        $display("FAIL %s op=%0d T%0d got=%h exp=%h", tag, op, k, got, expv);
      end
      @(posedge Clock); #1;
    end
  endtask

  task automatic check_idle(input string tag);
    n_checks++;
    if ({drv, ld, rsel, mem, alu_op, Run} !== 33'd0) begin
      n_fail++;
      $display("FAIL %s outputs got=%h exp=0", tag, {drv, ld, rsel, mem, alu_op, Run});
    end
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    @(posedge Clock); @(negedge Clock); check_idle("reset_c1");
    @(posedge Clock); @(negedge Clock); check_idle("reset_c2");
    Reset = 1'b0;
    @(posedge Clock); #1;
  endtask

  task automatic test_reset();
    IR = 32'h0; CON_FF = 1'b0; Stop = 1'b0;
    do_reset();
  endtask

  task automatic test_add();
    run_instr(5'd3, 1'b0, "add");
  endtask

  task automatic test_ld();
    run_instr(5'd0, 1'b0, "ld");
    run_instr(5'd1, 1'b0, "ldi");
    run_instr(5'd2, 1'b0, "st");
  endtask

  task automatic test_branch();
    run_instr(5'd19, 1'b0, "brx_nt");
    run_instr(5'd19, 1'b1, "brx_t");
  endtask

  task automatic test_mul();
    run_instr(5'd15, 1'b0, "mul");
    run_instr(5'd16, 1'b1, "div");
  endtask

  task automatic test_random();
    logic [4:0] op;
    for (int i = 0; i < 60; i++) begin
      op = 5'($urandom_range(0, 31));
      if (op == 5'd27) op = 5'd26;
      run_instr(op, 1'($urandom_range(0, 1)), "rand");
    end
  endtask

  task automatic test_reset_mid();
    logic        rin_seen;
    logic [31:0] r;
    r = $urandom();
    IR = {5'd3, r[26:0]};
    rin_seen = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge Clock);
      if (rsel[3]) rin_seen = 1'b1;
      if (k == 4) Reset = 1'b1;
      @(posedge Clock); #1;
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge Clock);
      if (rsel[3]) rin_seen = 1'b1;
      check_idle("reset_mid_rst");
      @(posedge Clock); #1;
    end
    n_checks++;
    if (rin_seen !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_rin got=%b exp=0", rin_seen);
    end
    Reset = 1'b0;
    @(posedge Clock); #1;
    run_instr(5'd11, 1'b0, "after_reset");
  endtask

  task automatic test_halt();
    run_instr(5'd27, 1'b0, "halt");
    for (int i = 0; i < 20; i++) begin
      @(negedge Clock);
      IR = $urandom();
      check_idle("halt_hold");
    end
    do_reset();
    run_instr(5'd3, 1'b0, "post_halt");
  endtask

`ifdef CU_STOP_EN
  task automatic test_stop();
    Stop = 1'b1;
    run_instr(5'd23, 1'b0, "out_stop");
    for (int i = 0; i < 4; i++) begin
      @(negedge Clock);
      check_idle("stopped");
    end
    Stop = 1'b0;
    @(posedge Clock); #1;
    run_instr(5'd24, 1'b0, "after_stop");
  endtask
`endif

  initial begin
    Reset = 1'b0; IR = 32'h0; CON_FF = 1'b0; Stop = 1'b0;
    test_reset();
    test_add();
    test_ld();
    test_branch();
    test_mul();
    test_random();
    test_reset_mid();
`ifdef CU_STOP_EN
    test_stop();
`endif
    test_halt();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
